// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer and the branch unit.
// Holds the sequencer state enum, the fixed PC step and the alignment mask
// helper keyed on the instruction alignment (16 or 32 bits).
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } pc_state_t;

  // The sequencer always advances by a full word, even with compressed
  // instructions enabled (IALIGN=16).
  localparam int STEP = 4;

  // Low address bits that must be zero for a legal target.
  function automatic logic [1:0] align_mask(input int ialign);
    return (ialign == 16) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_align_check.sv
// Instruction-address alignment check, shared with the branch unit.
// Ports: target (candidate address) -> aligned (1 when the low bits selected
// by IALIGN are all zero). Purely combinational.
module pc_align_check
  import pc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IALIGN     = 32
) (
  input  logic [DATA_WIDTH-1:0] target,
  output logic                  aligned
);

  // Only the two low bits matter; fold the rest away explicitly.
  logic unused_hi;
  assign unused_hi = ^target[DATA_WIDTH-1:2];

  assign aligned = ((target[1:0] & align_mask(IALIGN)) == 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT -> FETCH, redirects, misaligned-target trap.
// Ports: clk/reset (sync, active-high); stall, redirect_valid/redirect_target,
// fetch_ready in; fetch_valid, PC, pc_plus_step, misaligned, fetch_count out.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    IALIGN       = 32,
  parameter int                    CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_target,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] pc_plus_step,
  output logic                  misaligned,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  localparam logic [DATA_WIDTH-1:0] STEP_W = DATA_WIDTH'(STEP);
  localparam logic [1:0]            RV_LOW = RESET_VECTOR[1:0];

  // Configuration sanity checks, resolved at elaboration.
  if (IALIGN != 16 && IALIGN != 32) begin : g_bad_ialign
    $error("pc_sequencer: IALIGN must be 16 or 32");
  end
  if ((RV_LOW & align_mask(IALIGN)) != 2'b00) begin : g_bad_reset_vector
    $error("pc_sequencer: RESET_VECTOR violates IALIGN alignment");
  end

  pc_state_t state, state_nxt;
  logic      target_aligned;
  logic      handshake;

  pc_align_check #(
    .DATA_WIDTH (DATA_WIDTH),
    .IALIGN     (IALIGN)
  ) u_align (
    .target  (redirect_target),
    .aligned (target_aligned)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: a redirect wins over everything except reset and
  // decides FETCH vs TRAP purely on target alignment, from any state.
  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = target_aligned ? FETCH : TRAP;
    end else begin
      case (state)
        BOOT:    state_nxt = FETCH;
        FETCH:   state_nxt = FETCH;
        TRAP:    state_nxt = TRAP;
        default: state_nxt = BOOT;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    fetch_valid = (state == FETCH) && !stall;
  end

  assign handshake    = fetch_valid && fetch_ready;
  assign pc_plus_step = PC + STEP_W;

  // Datapath. A redirect swallows a coincident handshake: the PC takes the
  // target and the fetch is not counted. On a misaligned redirect the target
  // is still loaded so the trap handler can see the offending address.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC          <= RESET_VECTOR;
      misaligned  <= 1'b0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      PC         <= redirect_target;
      misaligned <= !target_aligned;
    end else if (handshake) begin
      PC          <= pc_plus_step;
      fetch_count <= fetch_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized
// traffic compared against a rule-level reference model.
// Ports: none (top-level bench).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        fetch_ready = 1'b0;
  logic        fetch_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        misaligned;
  logic [15:0] fetch_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: booting/trapped flags, PC, counter, trap flag.
  logic [31:0] m_pc   = 32'h100;
  logic [15:0] m_cnt  = '0;
  logic        m_boot = 1'b1;
  logic        m_trap = 1'b0;
  logic        m_mis  = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h100),
    .IALIGN       (32),
    .CNT_WIDTH    (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .PC              (pc),
    .pc_plus_step    (pc_plus_step),
    .misaligned      (misaligned),
    .fetch_count     (fetch_count)
  );

  function automatic logic m_fv();
    return !m_boot && !m_trap && !stall;
  endfunction

  task automatic drive(input logic r, input logic s, input logic rv,
                       input logic [31:0] t, input logic rdy);
    reset = r; stall = s; redirect_valid = rv; redirect_target = t; fetch_ready = rdy;
  endtask

  // Advance one clock; the model applies the rules with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_pc = 32'h100; m_cnt = 0; m_boot = 1; m_trap = 0; m_mis = 0;
    end else if (redirect_valid) begin
      m_pc   = redirect_target;
      m_boot = 0;
      m_trap = (redirect_target % 4) != 0;
      m_mis  = m_trap;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (!m_trap && !stall && fetch_ready) begin
      m_pc  = m_pc + 4;
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    tick(); tick();
    n_total++; if (pc !== 32'h100) $display("FAIL reset_pc got=%h want=%h", pc, 32'h100); else n_pass++;
    n_total++; if (fetch_count !== 16'h0) $display("FAIL reset_cnt got=%h want=0", fetch_count); else n_pass++;
    n_total++; if (misaligned !== 1'b0) $display("FAIL reset_mis got=%b want=0", misaligned); else n_pass++;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL reset_fv got=%b want=0", fetch_valid); else n_pass++;
    drive(0, 0, 0, 0, 0);
    #1;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL boot_fv got=%b want=0", fetch_valid); else n_pass++;
    tick();
    n_total++; if (fetch_valid !== 1'b1) $display("FAIL post_boot_fv got=%b want=1", fetch_valid); else n_pass++;
    n_total++; if (pc !== 32'h100) $display("FAIL post_boot_pc got=%h want=%h", pc, 32'h100); else n_pass++;
  endtask

  task automatic test_fetch();
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick();
    n_total++; if (pc !== 32'h10C) $display("FAIL fetch_pc got=%h want=%h", pc, 32'h10C); else n_pass++;
    n_total++; if (fetch_count !== 16'd3) $display("FAIL fetch_cnt got=%0d want=3", fetch_count); else n_pass++;
    n_total++; if (pc_plus_step !== 32'h110) $display("FAIL fetch_pps got=%h want=%h", pc_plus_step, 32'h110); else n_pass++;
  endtask

  task automatic test_stall();
    drive(0, 1, 0, 0, 1);
    #1;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL stall_fv got=%b want=0", fetch_valid); else n_pass++;
    tick(); tick();
    n_total++; if (pc !== 32'h10C) $display("FAIL stall_pc got=%h want=%h", pc, 32'h10C); else n_pass++;
    n_total++; if (fetch_count !== 16'd3) $display("FAIL stall_cnt got=%0d want=3", fetch_count); else n_pass++;
  endtask

  task automatic test_redirect();
    drive(0, 0, 1, 32'h200, 1);
    #1;
    n_total++; if (fetch_valid !== 1'b1) $display("FAIL redir_fv got=%b want=1", fetch_valid); else n_pass++;
    tick();
    n_total++; if (pc !== 32'h200) $display("FAIL redir_pc got=%h want=%h", pc, 32'h200); else n_pass++;
    n_total++; if (fetch_count !== 16'd3) $display("FAIL redir_cnt got=%0d want=3", fetch_count); else n_pass++;
  endtask

  task automatic test_trap();
    drive(0, 0, 1, 32'h202, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    #1;
    n_total++; if (misaligned !== 1'b1) $display("FAIL trap_mis got=%b want=1", misaligned); else n_pass++;
    n_total++; if (pc !== 32'h202) $display("FAIL trap_pc got=%h want=%h", pc, 32'h202); else n_pass++;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL trap_fv got=%b want=0", fetch_valid); else n_pass++;
    tick();
    n_total++; if (pc !== 32'h202) $display("FAIL trap_hold_pc got=%h want=%h", pc, 32'h202); else n_pass++;
    n_total++; if (fetch_count !== 16'd3) $display("FAIL trap_hold_cnt got=%0d want=3", fetch_count); else n_pass++;
    drive(0, 0, 1, 32'h207, 0);
    tick();
    n_total++; if (pc !== 32'h207) $display("FAIL trap_re_pc got=%h want=%h", pc, 32'h207); else n_pass++;
    n_total++; if (misaligned !== 1'b1) $display("FAIL trap_re_mis got=%b want=1", misaligned); else n_pass++;
    drive(0, 0, 1, 32'h300, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    n_total++; if (misaligned !== 1'b0) $display("FAIL trap_exit_mis got=%b want=0", misaligned); else n_pass++;
    n_total++; if (pc !== 32'h300) $display("FAIL trap_exit_pc got=%h want=%h", pc, 32'h300); else n_pass++;
    n_total++; if (fetch_valid !== 1'b1) $display("FAIL trap_exit_fv got=%b want=1", fetch_valid); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    drive(0, 0, 1, 32'hFFFF_FFFC, 0);
    tick();
    n_total++; if (pc_plus_step !== 32'h0) $display("FAIL wrap_pps got=%h want=0", pc_plus_step); else n_pass++;
    drive(0, 0, 0, 0, 1);
    tick();
    n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc got=%h want=0", pc); else n_pass++;
    n_total++; if (misaligned !== 1'b0) $display("FAIL wrap_mis got=%b want=0", misaligned); else n_pass++;
    n_total++; if (fetch_count !== m_cnt) $display("FAIL wrap_cnt got=%0d want=%0d", fetch_count, m_cnt); else n_pass++;
  endtask

  task automatic test_count_wrap();
    int guard = 0;
    drive(0, 0, 0, 0, 1);
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      tick();
      guard++;
    end
    n_total++; if (fetch_count !== 16'hFFFF) $display("FAIL cnt_full got=%h want=ffff", fetch_count); else n_pass++;
    tick();
    n_total++; if (fetch_count !== 16'h0) $display("FAIL cnt_wrap got=%h want=0", fetch_count); else n_pass++;
  endtask

  task automatic test_reset_in_trap();
    drive(0, 0, 1, 32'h13, 0);
    tick();
    n_total++; if (misaligned !== 1'b1) $display("FAIL rst_trap_pre got=%b want=1", misaligned); else n_pass++;
    drive(1, 0, 1, 32'h400, 1);
    tick();
    n_total++; if (pc !== 32'h100) $display("FAIL rst_trap_pc got=%h want=%h", pc, 32'h100); else n_pass++;
    n_total++; if (misaligned !== 1'b0) $display("FAIL rst_trap_mis got=%b want=0", misaligned); else n_pass++;
    n_total++; if (fetch_count !== 16'h0) $display("FAIL rst_trap_cnt got=%h want=0", fetch_count); else n_pass++;
    n_total++; if (fetch_valid !== 1'b0) $display("FAIL rst_trap_fv got=%b want=0", fetch_valid); else n_pass++;
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0), t, ($urandom_range(0, 3) != 0));
      #1;
      n_total++;
      if (fetch_valid !== m_fv()) begin
        if (errs < 10) $display("FAIL rnd_fv cyc=%0d got=%b want=%b", i, fetch_valid, m_fv());
        errs++;
      end else n_pass++;
      tick();
      n_total++;
      if (pc !== m_pc || fetch_count !== m_cnt || misaligned !== m_mis ||
          pc_plus_step !== m_pc + 32'd4) begin
        if (errs < 10)
          $display("FAIL rnd_state cyc=%0d pc=%h/%h cnt=%h/%h mis=%b/%b pps=%h/%h",
                   i, pc, m_pc, fetch_count, m_cnt, misaligned, m_mis, pc_plus_step, m_pc + 32'd4);
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_trap();
    test_pc_wrap();
    test_count_wrap();
    test_reset_in_trap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have a single clock `clk` and a synchronous, active-high reset `reset`.
REQ-002 Parameter: DATA_WIDTH, default 32, PC width in bits.
REQ-003 Parameter: RESET_VECTOR, default 32'h0000_0000, PC value loaded by reset.
REQ-004 Parameter: IALIGN, default 32; legal values are 16 and 32; instruction alignment in bits.
REQ-005 Parameter: CNT_WIDTH, default 16, width of the fetch counter.
REQ-006 Port `clk`, input, 1, rising-edge clock.
REQ-007 Port `reset`, input, 1, synchronous active-high reset.
REQ-008 Port `stall`, input, 1, freezes PC advance.
REQ-009 Port `redirect_valid`, input, 1, branch/jump/trap redirect request.
REQ-010 Port `redirect_target`, input, DATA_WIDTH, redirect address.
REQ-011 Port `fetch_ready`, input, 1, instruction memory accepts the current PC.
REQ-012 Port `fetch_valid`, output, 1, PC is presented for fetch.
REQ-013 Port `PC`, output, DATA_WIDTH, registered current PC.
REQ-014 Port `pc_plus_step`, output, DATA_WIDTH, combinational PC + STEP, used as the link address.
REQ-015 Port `misaligned`, output, 1, registered trap flag.
REQ-016 Port `fetch_count`, output, CNT_WIDTH, count of completed fetch handshakes.

Function
REQ-017 STEP SHALL be 4 when IALIGN=32; when IALIGN=16, STEP SHALL be 4, since the sequencer always steps by a full word.
REQ-018 The FSM SHALL have three states: BOOT, FETCH and TRAP.
REQ-019 BOOT SHALL last exactly one cycle after reset deasserts, then transition to FETCH with PC unchanged.
REQ-020 `fetch_valid` SHALL equal (state==FETCH) AND NOT `stall`; this is combinational from state and stall.
REQ-021 The handshake SHALL complete on a cycle where `fetch_valid` and `fetch_ready` are both 1; on that edge PC <= PC + STEP and `fetch_count` increments.
REQ-022 PC arithmetic SHALL be modulo 2^DATA_WIDTH; all-ones minus 3 plus 4 wraps to 0 with no flag.
REQ-023 `fetch_count` SHALL wrap from all-ones to 0.
REQ-024 Priority SHALL be: reset > redirect_valid > stall > handshake.
REQ-025 On a redirect in FETCH or BOOT with an aligned target, PC <= redirect_target, state <= FETCH, and no count increment, even if a handshake completes in the same cycle.
REQ-026 A target is aligned when target[1:0]==0 (IALIGN=32) or target[0]==0 (IALIGN=16).
REQ-027 A misaligned redirect SHALL cause PC <= redirect_target (held for trap value), `misaligned` <= 1 and state <= TRAP.
REQ-028 In TRAP, `fetch_valid`=0 and PC holds; only an aligned redirect SHALL exit, clearing `misaligned` and entering FETCH at the target.
REQ-029 A misaligned redirect in TRAP SHALL update PC and remain in TRAP.
REQ-030 While `stall`=1 in FETCH with no redirect, PC and `fetch_count` SHALL hold, irrespective of `fetch_ready`.
REQ-031 `pc_plus_step` SHALL always equal PC + STEP, truncated to DATA_WIDTH.

Reset
REQ-032 Reset SHALL set PC=RESET_VECTOR, state=BOOT, `misaligned`=0 and `fetch_count`=0; `fetch_valid` is therefore 0.
REQ-033 Reset asserted mid-operation (any state, including TRAP) SHALL override all inputs on that edge.
REQ-034 RESET_VECTOR SHALL satisfy the IALIGN rule; a misaligned RESET_VECTOR is a configuration error flagged by an elaboration-time check.

Structure
REQ-035 Package `pc_pkg` SHALL hold the state enum (BOOT/FETCH/TRAP) and the STEP constant, plus the alignment-mask function keyed on IALIGN.
REQ-036 The alignment check SHALL be one sub-module, `pc_align_check` (target, IALIGN -> aligned), reusable by the branch unit; all other logic stays in pc_sequencer.

Verification
REQ-037 Scenario: reset high for 2 cycles with RESET_VECTOR=0x100, then released -> PC=0x100; `fetch_valid`=0 for 1 cycle, then 1.
REQ-038 Scenario: `fetch_ready`=1 for 3 cycles from PC=0x100 -> PC=0x10C, `fetch_count`=3, `pc_plus_step`=0x110.
REQ-039 Scenario: `stall`=1 with `fetch_ready`=1 for 2 cycles at PC=0x10C -> PC stays 0x10C, `fetch_valid`=0, count stays 3.
REQ-040 Scenario: `redirect_valid`=1 with target 0x200, simultaneous with a handshake -> PC=0x200, count unchanged.
REQ-041 Scenario: redirect to 0x202 (IALIGN=32) -> `misaligned`=1, PC=0x202, `fetch_valid`=0; then redirect to 0x300 -> `misaligned`=0, PC=0x300, state FETCH.
REQ-042 Scenario: PC=0xFFFF_FFFC with a handshake -> PC=0x0000_0000; `fetch_count` at 0xFFFF with a handshake -> 0x0000.
